// File: rtl/fp_divider32_seq_if.sv
// Operand/result handshake bundle for the sequential FP divider.
interface fp_divider32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Divider side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_divider32_seq.sv
// Sequential binary32 divider: one restoring quotient bit per clock, then a
// single normalize/round cycle. Number handling mirrors multiplier32: implicit
// leading one, no special cases, 8-bit wrapping exponent.
module fp_divider32_seq #(
  parameter int unsigned EXP_BIAS = 127,
  parameter int unsigned Q_BITS   = 26
) (
  input logic                clk,
  input logic                rst_n,
  fp_divider32_seq_if.slave  bus
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned DIV_W  = MANT_W + 1;
  localparam int unsigned REM_W  = MANT_W + 2;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, state_next;
  logic                sign, sign_next;
  logic [EXP_W-1:0]    exp_tmp, exp_tmp_next;
  logic [REM_W-1:0]    rem, rem_next;
  logic [DIV_W-1:0]    div, div_next;
  logic [Q_BITS-1:0]   q, q_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                in_rdy, in_rdy_next;
  logic                out_vld, out_vld_next;
  logic [DATA_W-1:0]   result, result_next;

  // Divide-step and rounding helpers
  logic                ge_c;
  logic [REM_W-1:0]    diff_c;
  logic [MANT_W-1:0]   mant_pre_c;
  logic [MANT_W-1:0]   mant_rnd_c;
  logic                rbit_c;
  logic [EXP_W-1:0]    exp_out_c;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign    <= 1'b0;
      exp_tmp <= '0;
      rem     <= '0;
      div     <= '0;
      q       <= '0;
      cnt     <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      result  <= '0;
    end else begin
      sign    <= sign_next;
      exp_tmp <= exp_tmp_next;
      rem     <= rem_next;
      div     <= div_next;
      q       <= q_next;
      cnt     <= cnt_next;
      in_rdy  <= in_rdy_next;
      out_vld <= out_vld_next;
      result  <= result_next;
    end
  end

  // Restoring step and round/normalize arithmetic
  always_comb begin
    diff_c = rem - REM_W'({1'b0, div});
    ge_c   = (rem >= REM_W'({1'b0, div}));
    if (q[Q_BITS-1]) begin
      mant_pre_c = q[Q_BITS-2:2];
      rbit_c     = q[1];
      exp_out_c  = exp_tmp + EXP_W'(EXP_BIAS);
    end else begin
      mant_pre_c = q[Q_BITS-3:1];
      rbit_c     = q[0];
      exp_out_c  = exp_tmp + EXP_W'(EXP_BIAS - 1);
    end
    // Carry out of the mantissa is dropped, exponent left alone
    mant_rnd_c = mant_pre_c + MANT_W'(rbit_c);
  end

  // Next-state and register-next logic
  always_comb begin
    state_next   = state;
    sign_next    = sign;
    exp_tmp_next = exp_tmp;
    rem_next     = rem;
    div_next     = div;
    q_next       = q;
    cnt_next     = cnt;
    result_next  = result;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next    = bus.in_a[31] ^ bus.in_b[31];
          exp_tmp_next = bus.in_a[30:23] - bus.in_b[30:23];
          rem_next     = {1'b0, 1'b1, bus.in_a[22:0]};
          div_next     = {1'b1, bus.in_b[22:0]};
          q_next       = '0;
          cnt_next     = CNT_W'(Q_BITS - 1);
          state_next   = DIVIDE;
        end
      end
      DIVIDE: begin
        // Quotient bits arrive MSB first, so shift them in from the right
        q_next   = {q[Q_BITS-2:0], ge_c};
        rem_next = (ge_c ? diff_c : rem) << 1;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        result_next = {sign, exp_out_c, mant_rnd_c};
        state_next  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    in_rdy_next  = (state_next == IDLE);
    out_vld_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_fp_divider32_seq.sv
// Self-checking bench for fp_divider32_seq: directed cases, backpressure,
// mid-operation reset and random operands against an arithmetic model.
module tb_fp_divider32_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fp_divider32_seq_if bus();

  fp_divider32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference: real-valued quotient of the two significands scaled by 2^25,
  // normalized, rounded half-up on the first dropped bit, exponent mod 256.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, qv, mant, r;
    int e;
    ma = 64'(a[22:0]) + 64'h800000;
    mb = 64'(b[22:0]) + 64'h800000;
    qv = (ma * 64'd33554432) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]);
    if (qv >= 64'd33554432) begin
      mant = (qv / 4) % 64'd8388608;
      r    = (qv / 2) % 2;
      e    = e + 127;
    end else begin
      mant = (qv / 2) % 64'd8388608;
      r    = qv % 2;
      e    = e + 126;
    end
    mant = (mant + r) % 64'd8388608;
    e    = ((e % 256) + 256) % 256;
    return {a[31] ^ b[31], 8'(e), 23'(mant)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; bp = cycles out_ready stays low once out_valid is up,
  // disturb = pulse in_valid with junk operands while the divide is running.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int bp, input bit disturb);
    logic [31:0] exp;
    int lat;
    exp = ref_div(a, b);
    lat = -1;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    for (int n = 1; n <= 40; n++) begin
      if (disturb && n == 5) begin
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = $urandom;
      end
      if (disturb && n == 6) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    // out_valid is up after 27 edges, i.e. seen by the consumer at edge k+28
    chk("latency", 32'(lat), 32'd27);
    if (lat < 0) return;
    chk("result", bus.out_data, exp);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", bus.out_data, exp);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hs_valid_low", 32'(bus.out_valid), 32'd0);
    chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hs_data_held", bus.out_data, exp);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, with fixed expected encodings
    chk("ref_6_2", ref_div(32'h40C00000, 32'h40000000), 32'h40400000);
    run_op(32'h40C00000, 32'h40000000, 0, 1'b0);
    chk("ref_1_3", ref_div(32'h3F800000, 32'h40400000), 32'h3EAAAAAB);
    run_op(32'h3F800000, 32'h40400000, 0, 1'b0);
    run_op(32'hC0F00000, 32'h40200000, 1, 1'b0);
    chk("ref_m75_25", ref_div(32'hC0F00000, 32'h40200000), 32'hC0400000);
    run_op(32'h3FC00000, 32'h3FC00000, 0, 1'b0);
    chk("ref_exact", ref_div(32'h3FC00000, 32'h3FC00000), 32'h3F800000);

    // Backpressure with a stray operand pulse during the divide
    run_op(32'h40C00000, 32'h40000000, 5, 1'b1);

    // Reset 10 cycles into a divide: drops immediately, nothing emitted after
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h40C00000;
    bus.in_b     = 32'h40000000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_data", bus.out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("no_stale_result", 32'(seen), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 0, 1'b0);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      run_op($urandom, $urandom, int'($urandom_range(0, 2)), 1'(i % 3 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
